ats21_cmd_arbiter: RTL and testbench
====================================

# ats21_cmd_arbiter

Front-end command arbiter for the ATS21 alarm/timer system. It sits between the two host clients (A and B) and the ATS21 instruction execution core. It deserializes each client's 32-bit instruction from two 16-bit beats, including staggered requests, and buffers each client's instructions in its own FIFO. It issues one instruction at a time to the core over a valid/ready handshake, with round-robin fairness between A and B.

## Interface
- DEPTH, 4: entries per client FIFO (power of two, ≥2)
- CW, $clog2(DEPTH+1): FIFO occupancy counter width (derived)

- clk  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- req  input  1  client request strobe (shared by A and B)
- ctrlA  input  16  client A instruction beat
- ctrlB  input  16  client B instruction beat
- ready  output  1  registered; high when neither FIFO is full
- cmd_valid  output  1  instruction available to core
- cmd_word  output  32  {upper beat, lower beat} of granted instruction
- cmd_client  output  1  0 = A, 1 = B
- cmd_ready  input  1  core accepts cmd_word this cycle
- drop_a  output  1  one-cycle pulse: A instruction lost to full FIFO
- drop_b  output  1  one-cycle pulse: B instruction lost to full FIFO

## Operation
- Each client has an independent 2-state assembler: IDLE, LOW.
  - IDLE → LOW: at a posedge with req=1 and ctrlX[15:13]≠3'b000. ctrlX is latched as the upper beat.
  - LOW → IDLE: unconditionally at the next posedge. ctrlX is taken as the lower beat, regardless of req or opcode. The 32-bit word is pushed into FIFO X.
  - In IDLE, req=1 with opcode 000 is a Nop: nothing is captured.
- Staggered requests are handled by the same rules:
  - req high two consecutive cycles, with A's upper beat in cycle 0 (B opcode 000), then A's lower beat and B's upper beat in cycle 1.
  - A completes at the end of cycle 1; B completes at the end of cycle 2.
- FIFO X push when full:
  - No pop this cycle: the word is discarded, drop_x pulses high for one cycle, and the FIFO is unchanged.
  - Pop of FIFO X this cycle: the push is accepted and count stays DEPTH.
- Push and pop of the same FIFO in one cycle: count unchanged, order preserved.
- Arbitration (combinational from registered state):
  - Only one FIFO non-empty: grant that FIFO.
  - Both non-empty: grant the client opposite to the last-served pointer `last`.
- cmd_valid = (countA≠0) | (countB≠0). cmd_word and cmd_client show the head of the granted FIFO.
- On cmd_valid & cmd_ready: pop the granted FIFO and set `last` = cmd_client. `last` changes only on a pop.
- While cmd_valid=1 and cmd_ready=0, cmd_word and cmd_client are held stable. A push to the other FIFO does not change the grant until the pending instruction is taken.
- Counters: CW bits; pointers: $clog2(DEPTH) bits, wrapping modulo DEPTH.

## Timing
- Reset values:
  - Both assemblers IDLE, both counts 0, all pointers 0, `last` = B (so A wins the first tie).
  - ready=1, cmd_valid=0, cmd_word=0, cmd_client=0, drop_a=0, drop_b=0.
- Reset mid-instruction: a partially assembled instruction is abandoned; no push occurs.
- Latency: upper beat sampled at edge E0, lower beat at E1. With both FIFOs empty, cmd_valid rises in the cycle after E1, one cycle after the lower beat.
- A pop at edge E makes the next head or grant visible in the cycle after E.
- Throughput: one instruction issued per cycle while cmd_ready=1.
- ready reflects counts after the current edge's push/pop.
  - A client seeing ready=0 must not start a new request.
  - An in-flight LOW beat is still accepted per the full-FIFO rules.
- drop_x is asserted in the cycle after the edge that discarded the word.

## Test plan
- **Single A instruction.** Reset 4 cycles. Drive req=1 with ctrlA=16'h2000 (B=0000), then req=0 with ctrlA=16'h0000. Required: one cycle later cmd_valid=1, cmd_word=32'h2000_0000, cmd_client=0. With cmd_ready=1 it pops; cmd_valid=0 the next cycle.
- **Simultaneous A and B.** A upper=16'h2000, B upper=16'h2240, both lower=16'h0000, cmd_ready=1. Required: A issued first (32'h2000_0000), then B (32'h2240_0000) the next cycle; `last`=B afterwards.
- **Staggered request.** req high 2 cycles: A beats 16'hA000→16'h0025, B beats 16'h0000→16'hA000→16'h0025. Required: A word 32'hA000_0025 and B word 32'hA000_0025, with B available exactly one cycle after A. No drop pulses.
- **Round-robin under backpressure.** cmd_ready=0 while pushing A0, A1, B0, B1, then cmd_ready=1. Required issue order: A0, B0, A1, B1. cmd_word stays stable while stalled.
- **Overflow.** cmd_ready=0; push DEPTH+1 A instructions (4+1 at default DEPTH). Required: ready=0 after the 4th push; drop_a pulses once for the 5th. The first 4 issue in order afterwards.
- **Reset mid-op.** Assert reset in the LOW cycle after an A upper beat of 16'hC102. Required: no instruction issued, all outputs at their reset values. The next clean instruction works normally.

Source files
------------

// File: rtl/ats21_cmd_arbiter_if.sv
// Handshake bundle between the two host clients, the arbiter and the
// instruction execution core. The arbiter uses the slave view; whoever
// drives the clients and the core side uses the master view.
interface ats21_cmd_arbiter_if;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        ready;
    logic        cmd_valid;
    logic [31:0] cmd_word;
    logic        cmd_client;
    logic        cmd_ready;
    logic        drop_a;
    logic        drop_b;

    modport slave (
        input  req, ctrlA, ctrlB, cmd_ready,
        output ready, cmd_valid, cmd_word, cmd_client, drop_a, drop_b
    );

    modport master (
        output req, ctrlA, ctrlB, cmd_ready,
        input  ready, cmd_valid, cmd_word, cmd_client, drop_a, drop_b
    );
endinterface

// File: rtl/ats21_cmd_arbiter.sv
// ATS21 command arbiter: assembles two-beat instructions from clients A and
// B, queues them per client and issues them one at a time to the core with
// round-robin fairness. Index 0 of every per-client array is client A.
module ats21_cmd_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    ats21_cmd_arbiter_if.slave   bus
);
    localparam int             PW       = $clog2(DEPTH);
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        ASM_IDLE = 1'b0,
        ASM_LOW  = 1'b1
    } asm_state_t;

    asm_state_t    asm_q [2];
    asm_state_t    asm_d [2];
    logic [15:0]   upper_q [2];
    logic [15:0]   upper_d [2];
    logic [15:0]   ctrl_s [2];
    logic          push_s [2];
    logic [31:0]   push_word_s [2];

    logic [31:0]   mem_q [2][DEPTH];
    logic [PW-1:0] wr_q [2];
    logic [PW-1:0] rd_q [2];
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic          acc_s [2];
    logic          pop_s [2];
    logic          nonempty_s [2];

    logic          valid_s;
    logic          grant_s;
    logic          last_q, last_d;
    logic          hold_q, hold_d;
    logic          held_q;
    logic          ready_q, ready_d;
    logic          drop_a_q, drop_b_q;

    assign ctrl_s[0] = bus.ctrlA;
    assign ctrl_s[1] = bus.ctrlB;

    // Per-client assembler: capture the upper beat, then push on the lower beat.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            asm_d[c]       = asm_q[c];
            upper_d[c]     = upper_q[c];
            push_s[c]      = 1'b0;
            push_word_s[c] = 32'h0000_0000;
            case (asm_q[c])
                ASM_IDLE: begin
                    if (bus.req && (ctrl_s[c][15:13] != 3'b000)) begin
                        asm_d[c]   = ASM_LOW;
                        upper_d[c] = ctrl_s[c];
                    end else begin
                        asm_d[c]   = ASM_IDLE;
                    end
                end
                ASM_LOW: begin
                    asm_d[c]       = ASM_IDLE;
                    push_s[c]      = 1'b1;
                    push_word_s[c] = {upper_q[c], ctrl_s[c]};
                end
                default: asm_d[c] = ASM_IDLE;
            endcase
        end
    end

    // Grant selection; a stalled grant is pinned so the presented word stays stable.
    always_comb begin
        nonempty_s[0] = (cnt_q[0] != {CW{1'b0}});
        nonempty_s[1] = (cnt_q[1] != {CW{1'b0}});
        valid_s       = nonempty_s[0] || nonempty_s[1];
        if (hold_q) begin
            grant_s = held_q;
        end else if (nonempty_s[0] && nonempty_s[1]) begin
            grant_s = ~last_q;
        end else if (nonempty_s[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        pop_s[0] = valid_s && bus.cmd_ready && !grant_s;
        pop_s[1] = valid_s && bus.cmd_ready &&  grant_s;
        hold_d   = valid_s && !bus.cmd_ready;
        if (valid_s && bus.cmd_ready) begin
            last_d = grant_s;
        end else begin
            last_d = last_q;
        end
    end

    // Occupancy update; a full FIFO still accepts a push when it pops in the same cycle.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            acc_s[c] = push_s[c] && ((cnt_q[c] != FULL_CNT) || pop_s[c]);
            case ({acc_s[c], pop_s[c]})
                2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
                2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
                default: cnt_d[c] = cnt_q[c];
            endcase
        end
        ready_d = (cnt_d[0] != FULL_CNT) && (cnt_d[1] != FULL_CNT);
    end

    assign bus.cmd_valid  = valid_s;
    assign bus.cmd_word   = valid_s ? mem_q[grant_s][rd_q[grant_s]] : 32'h0000_0000;
    assign bus.cmd_client = valid_s && grant_s;
    assign bus.ready      = ready_q;
    assign bus.drop_a     = drop_a_q;
    assign bus.drop_b     = drop_b_q;

    // Control state: assemblers, pointers, counts, fairness and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                asm_q[c]   <= ASM_IDLE;
                upper_q[c] <= 16'h0000;
                wr_q[c]    <= {PW{1'b0}};
                rd_q[c]    <= {PW{1'b0}};
                cnt_q[c]   <= {CW{1'b0}};
            end
            last_q   <= 1'b1;
            hold_q   <= 1'b0;
            held_q   <= 1'b0;
            ready_q  <= 1'b1;
            drop_a_q <= 1'b0;
            drop_b_q <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                asm_q[c]   <= asm_d[c];
                upper_q[c] <= upper_d[c];
                cnt_q[c]   <= cnt_d[c];
                if (acc_s[c]) begin
                    wr_q[c] <= wr_q[c] + PW'(1);
                end
                if (pop_s[c]) begin
                    rd_q[c] <= rd_q[c] + PW'(1);
                end
            end
            last_q   <= last_d;
            hold_q   <= hold_d;
            held_q   <= grant_s;
            ready_q  <= ready_d;
            drop_a_q <= push_s[0] && !acc_s[0];
            drop_b_q <= push_s[1] && !acc_s[1];
        end
    end

    // Instruction storage; contents are only observed through non-empty FIFOs.
    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (acc_s[c]) begin
                mem_q[c][wr_q[c]] <= push_word_s[c];
            end
        end
    end
endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// Directed bench for ats21_cmd_arbiter: a queue-based instruction-level model
// predicts every output each cycle, and literal expectations pin key points.
module tb_ats21_cmd_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_en = 1'b0;

    ats21_cmd_arbiter_if bus ();

    ats21_cmd_arbiter #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    bit          m_pend [2] = '{1'b0, 1'b0};
    logic [15:0] m_up [2];
    bit          m_last = 1'b1;
    bit          m_lock_v = 1'b0;
    bit          m_lock = 1'b0;
    bit          m_grant = 1'b0;
    bit          m_ready = 1'b1;
    bit          m_drop [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin : model
        logic [15:0] ctl [2];
        logic [31:0] pw [2];
        bit          push [2];
        bit          valid, pop;
        if (reset) begin
            qa.delete();
            qb.delete();
            m_pend   = '{1'b0, 1'b0};
            m_last   = 1'b1;
            m_lock_v = 1'b0;
            m_ready  = 1'b1;
            m_drop   = '{1'b0, 1'b0};
        end else begin
            ctl[0] = bus.ctrlA;
            ctl[1] = bus.ctrlB;
            valid  = (qa.size() + qb.size()) > 0;
            pop    = valid && bus.cmd_ready;
            for (int c = 0; c < 2; c++) begin
                push[c] = 1'b0;
                pw[c]   = 32'h0;
                if (m_pend[c]) begin
                    push[c]   = 1'b1;
                    pw[c]     = {m_up[c], ctl[c]};
                    m_pend[c] = 1'b0;
                end else if (bus.req && ctl[c][15:13] != 3'b000) begin
                    m_pend[c] = 1'b1;
                    m_up[c]   = ctl[c];
                end
            end
            m_drop[0] = push[0] && qa.size() == DEPTH && !(pop && !m_grant);
            m_drop[1] = push[1] && qb.size() == DEPTH && !(pop && m_grant);
            if (pop) begin
                if (m_grant) void'(qb.pop_front());
                else         void'(qa.pop_front());
                m_last = m_grant;
            end
            if (push[0] && !m_drop[0]) qa.push_back(pw[0]);
            if (push[1] && !m_drop[1]) qb.push_back(pw[1]);
            m_lock_v = valid && !bus.cmd_ready;
            m_lock   = m_grant;
            m_ready  = qa.size() < DEPTH && qb.size() < DEPTH;
        end
        if (m_lock_v)                          m_grant = m_lock;
        else if (qa.size() > 0 && qb.size() > 0) m_grant = !m_last;
        else                                   m_grant = (qb.size() > 0);
    end

    // Compare every output against the model in the middle of each cycle.
    always @(negedge clk) begin : compare
        bit          ev;
        logic [31:0] ew;
        if (chk_en) begin
            ev = (qa.size() + qb.size()) > 0;
            ew = !ev ? 32'h0 : (m_grant ? qb[0] : qa[0]);
            chk("m_cmd_valid",  32'(bus.cmd_valid),  32'(ev));
            chk("m_cmd_word",   bus.cmd_word,        ew);
            chk("m_cmd_client", 32'(bus.cmd_client), 32'(ev && m_grant));
            chk("m_ready",      32'(bus.ready),      32'(m_ready));
            chk("m_drop_a",     32'(bus.drop_a),     32'(m_drop[0]));
            chk("m_drop_b",     32'(bus.drop_b),     32'(m_drop[1]));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit r, input logic [15:0] a, input logic [15:0] b, input bit rdy);
        bus.req       = r;
        bus.ctrlA     = a;
        bus.ctrlB     = b;
        bus.cmd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step(1'b0, 16'h0, 16'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] hi, lo;
        bus.req = 1'b0; bus.ctrlA = 16'h0; bus.ctrlB = 16'h0; bus.cmd_ready = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        do_reset(4);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_cmd_word", bus.cmd_word, 32'h0);

        // Single A instruction
        step(1'b1, 16'h2000, 16'h0000, 1'b0);
        chk("t1_not_yet_valid", 32'(bus.cmd_valid), 32'd0);
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("t1_valid", 32'(bus.cmd_valid), 32'd1);
        chk("t1_word", bus.cmd_word, 32'h2000_0000);
        chk("t1_client", 32'(bus.cmd_client), 32'd0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t1_popped", 32'(bus.cmd_valid), 32'd0);

        // Simultaneous A and B
        do_reset(2);
        step(1'b1, 16'h2000, 16'h2240, 1'b1);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t2_first_word", bus.cmd_word, 32'h2000_0000);
        chk("t2_first_client", 32'(bus.cmd_client), 32'd0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t2_second_word", bus.cmd_word, 32'h2240_0000);
        chk("t2_second_client", 32'(bus.cmd_client), 32'd1);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t2_empty", 32'(bus.cmd_valid), 32'd0);

        // Staggered request
        do_reset(2);
        step(1'b1, 16'hA000, 16'h0000, 1'b1);
        step(1'b1, 16'h0025, 16'hA000, 1'b1);
        chk("t3_a_word", bus.cmd_word, 32'hA000_0025);
        chk("t3_a_client", 32'(bus.cmd_client), 32'd0);
        step(1'b0, 16'h0000, 16'h0025, 1'b1);
        chk("t3_b_word", bus.cmd_word, 32'hA000_0025);
        chk("t3_b_client", 32'(bus.cmd_client), 32'd1);
        chk("t3_no_drop_b", 32'(bus.drop_b), 32'd0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t3_empty", 32'(bus.cmd_valid), 32'd0);

        // Round-robin under backpressure: A0, A1, B0, B1 pushed while stalled
        do_reset(2);
        step(1'b1, 16'h2001, 16'h0000, 1'b0);
        step(1'b0, 16'h0001, 16'h0000, 1'b0);
        step(1'b1, 16'h2002, 16'h0000, 1'b0);
        step(1'b0, 16'h0002, 16'h0000, 1'b0);
        chk("t4_stall_word_a", bus.cmd_word, 32'h2001_0001);
        step(1'b1, 16'h0000, 16'h3001, 1'b0);
        step(1'b0, 16'h0000, 16'h0011, 1'b0);
        step(1'b1, 16'h0000, 16'h3002, 1'b0);
        step(1'b0, 16'h0000, 16'h0012, 1'b0);
        chk("t4_stall_word_b", bus.cmd_word, 32'h2001_0001);
        chk("t4_stall_client", 32'(bus.cmd_client), 32'd0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t4_issue2", bus.cmd_word, 32'h3001_0011);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t4_issue3", bus.cmd_word, 32'h2002_0002);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t4_issue4", bus.cmd_word, 32'h3002_0012);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t4_empty", 32'(bus.cmd_valid), 32'd0);

        // Overflow of FIFO A
        do_reset(2);
        for (int i = 0; i < DEPTH + 1; i++) begin
            hi = 16'h4000 + 16'(i);
            lo = 16'h0100 + 16'(i);
            step(1'b1, hi, 16'h0000, 1'b0);
            step(1'b0, lo, 16'h0000, 1'b0);
            if (i == DEPTH - 2) chk("t5_ready_before_full", 32'(bus.ready), 32'd1);
            if (i == DEPTH - 1) chk("t5_ready_full", 32'(bus.ready), 32'd0);
            if (i == DEPTH)     chk("t5_drop_a", 32'(bus.drop_a), 32'd1);
        end
        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk("t5_drop_a_clear", 32'(bus.drop_a), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t5_order", bus.cmd_word, {16'h4000 + 16'(i), 16'h0100 + 16'(i)});
            step(1'b0, 16'h0000, 16'h0000, 1'b1);
        end
        chk("t5_empty", 32'(bus.cmd_valid), 32'd0);
        chk("t5_ready_back", 32'(bus.ready), 32'd1);

        // Reset during the lower-beat cycle abandons the instruction
        do_reset(2);
        step(1'b1, 16'hC102, 16'h0000, 1'b1);
        reset = 1'b1;
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        reset = 1'b0;
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t6_valid", 32'(bus.cmd_valid), 32'd0);
        chk("t6_word", bus.cmd_word, 32'h0);
        chk("t6_ready", 32'(bus.ready), 32'd1);
        chk("t6_drop_a", 32'(bus.drop_a), 32'd0);
        step(1'b1, 16'h2000, 16'h0000, 1'b0);
        step(1'b0, 16'h0005, 16'h0000, 1'b0);
        chk("t6_clean_word", bus.cmd_word, 32'h2000_0005);
        chk("t6_clean_client", 32'(bus.cmd_client), 32'd0);
        step(1'b0, 16'h0000, 16'h0000, 1'b1);
        chk("t6_clean_popped", 32'(bus.cmd_valid), 32'd0);

        step(1'b0, 16'h0000, 16'h0000, 1'b0);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
